// File: rtl/alien_fleet_if.sv
// Signal bundle between game/alien-array logic and the alien fleet controller.
interface alien_fleet_if #(
    parameter int NUM_ALIENS = 8
);
    logic                  start;
    logic                  frame_tick;
    logic [NUM_ALIENS-1:0] alive_mask;
    logic [15:0]           fleet_left_x;
    logic [15:0]           fleet_right_x;
    logic                  shot_busy;
    logic                  movement_direction;
    logic [15:0]           movement_frequency;
    logic                  step_x;
    logic                  step_down;
    logic [15:0]           y_offset;
    logic [NUM_ALIENS-1:0] armed;
    logic                  fire_req;
    logic                  fleet_cleared;
    logic                  invaded;

    modport master (
        output start, frame_tick, alive_mask, fleet_left_x, fleet_right_x, shot_busy,
        input  movement_direction, movement_frequency, step_x, step_down, y_offset,
        input  armed, fire_req, fleet_cleared, invaded
    );

    modport slave (
        input  start, frame_tick, alive_mask, fleet_left_x, fleet_right_x, shot_busy,
        output movement_direction, movement_frequency, step_x, step_down, y_offset,
        output armed, fire_req, fleet_cleared, invaded
    );
endinterface

// File: rtl/alien_fleet_controller.sv
// Alien formation sequencer: shared march direction and step timing, edge-triggered
// drop-and-reverse, halt detection and a round-robin fire scheduler.
module alien_fleet_controller #(
    parameter int NUM_ALIENS       = 8,
    parameter int LEFT_BOUND       = 8,
    parameter int RIGHT_BOUND      = 152,
    parameter int MIN_PERIOD       = 1,
    parameter int PERIOD_PER_ALIEN = 2,
    parameter int DROP_ROWS        = 8,
    parameter int INVADE_OFFSET    = 96,
    parameter int FIRE_PERIOD      = 32
) (
    input logic          clk,
    input logic          rst_n,
    alien_fleet_if.slave bus
);
    localparam int PTR_W  = (NUM_ALIENS > 1) ? $clog2(NUM_ALIENS) : 1;
    localparam int FIRE_W = $clog2(FIRE_PERIOD + 1);
    localparam int DROP_W = $clog2(DROP_ROWS + 1);

    typedef enum logic [1:0] {IDLE, MARCH, DROP, HALT} state_t;
    state_t state, state_next;

    logic                  dir;
    logic [15:0]           period, frame_cnt, y_offset;
    logic [DROP_W-1:0]     drop_cnt;
    logic [FIRE_W-1:0]     fire_cnt;
    logic [PTR_W-1:0]      rr_ptr;
    logic [NUM_ALIENS-1:0] armed;
    logic                  step_x, step_down, fire_req, cleared, invaded;

    logic [15:0]      alive_count, period_next;
    logic [PTR_W-1:0] pick, probe;
    logic             pick_valid, at_edge, fire_now;
    logic             active, halt_clear, halt_invade, boundary, edge_hit, drop_tick, drop_done;

    always_comb begin
        alive_count = '0;
        for (int i = 0; i < NUM_ALIENS; i++) alive_count = alive_count + 16'(bus.alive_mask[i]);
    end
    assign period_next = 16'(MIN_PERIOD) + 16'(PERIOD_PER_ALIEN) * alive_count;

    // Round-robin search: lowest offset from rr_ptr wins, so scan offsets high to low.
    always_comb begin
        pick       = '0;
        probe      = '0;
        pick_valid = 1'b0;
        for (int k = NUM_ALIENS - 1; k >= 0; k--) begin
            probe = PTR_W'((int'(rr_ptr) + k) % NUM_ALIENS);
            if (bus.alive_mask[probe]) begin
                pick       = probe;
                pick_valid = 1'b1;
            end
        end
    end

    assign at_edge = dir ? (bus.fleet_right_x >= 16'(RIGHT_BOUND))
                         : (bus.fleet_left_x <= 16'(LEFT_BOUND));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        active      = 1'b0;
        halt_clear  = 1'b0;
        halt_invade = 1'b0;
        boundary    = 1'b0;
        edge_hit    = 1'b0;
        drop_tick   = 1'b0;
        drop_done   = 1'b0;
        if (state == MARCH || state == DROP) begin
            if (bus.alive_mask == '0) begin
                halt_clear = 1'b1;
                state_next = HALT;
            end else if (y_offset >= 16'(INVADE_OFFSET)) begin
                halt_invade = 1'b1;
                state_next  = HALT;
            end else begin
                active = 1'b1;
                if (state == MARCH) begin
                    if (bus.frame_tick && (({1'b0, frame_cnt} + 17'd1) >= {1'b0, period})) begin
                        boundary = 1'b1;
                        if (at_edge) begin
                            edge_hit   = 1'b1;
                            state_next = DROP;
                        end
                    end
                end else if (bus.frame_tick) begin
                    drop_tick = 1'b1;
                    if (drop_cnt == DROP_W'(DROP_ROWS - 1)) begin
                        drop_done  = 1'b1;
                        state_next = MARCH;
                    end
                end
            end
        end
        if (bus.start) state_next = MARCH;
    end

    assign fire_now = active && (fire_cnt == FIRE_W'(FIRE_PERIOD)) && !bus.shot_busy && pick_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir       <= 1'b1;
            period    <= '0;
            frame_cnt <= '0;
            y_offset  <= '0;
            drop_cnt  <= '0;
            fire_cnt  <= '0;
            rr_ptr    <= '0;
            armed     <= '0;
            step_x    <= 1'b0;
            step_down <= 1'b0;
            fire_req  <= 1'b0;
            cleared   <= 1'b0;
            invaded   <= 1'b0;
        end else begin
            period    <= period_next;
            step_x    <= 1'b0;
            step_down <= 1'b0;
            fire_req  <= 1'b0;
            if ((armed & ~bus.alive_mask) != '0) armed <= '0;
            if (bus.start) begin
                dir       <= 1'b1;
                frame_cnt <= '0;
                y_offset  <= '0;
                drop_cnt  <= '0;
                fire_cnt  <= '0;
                cleared   <= 1'b0;
                invaded   <= 1'b0;
            end else begin
                if (halt_clear)  cleared <= 1'b1;
                if (halt_invade) invaded <= 1'b1;
                if (halt_clear || halt_invade) armed <= '0;
                if (active && state == MARCH && bus.frame_tick)
                    frame_cnt <= boundary ? '0 : frame_cnt + 16'd1;
                step_x <= boundary && !edge_hit;
                if (edge_hit) drop_cnt <= '0;
                if (drop_tick) begin
                    step_down <= 1'b1;
                    y_offset  <= y_offset + 16'd1;
                    drop_cnt  <= drop_cnt + DROP_W'(1);
                end
                if (drop_done) begin
                    dir       <= !dir;
                    frame_cnt <= '0;
                end
                // A fire resets the interval even if a frame tick lands in the same cycle.
                if (fire_now) begin
                    armed    <= NUM_ALIENS'(1) << pick;
                    fire_req <= 1'b1;
                    rr_ptr   <= PTR_W'((int'(pick) + 1) % NUM_ALIENS);
                    fire_cnt <= '0;
                end else if (active && bus.frame_tick && fire_cnt != FIRE_W'(FIRE_PERIOD)) begin
                    fire_cnt <= fire_cnt + FIRE_W'(1);
                end
            end
        end
    end

    assign bus.movement_direction = dir;
    assign bus.movement_frequency = period;
    assign bus.step_x             = step_x;
    assign bus.step_down          = step_down;
    assign bus.y_offset           = y_offset;
    assign bus.armed              = armed;
    assign bus.fire_req           = fire_req;
    assign bus.fleet_cleared      = cleared;
    assign bus.invaded            = invaded;
endmodule
